// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the MIPS datapath. It latches the decoded operands and control,
// then applies EX-stage forwarding, ALU-source selection and ALU-control decode. The outputs
// feed the ALU and EX/MEM directly.
module id_ex_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [REGW-1:0]  id_rs,
  input  logic [REGW-1:0]  id_rt,
  input  logic [REGW-1:0]  id_rd,
  input  logic [5:0]       id_funct,
  input  logic [2:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic [4:0]       id_ctrl,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             ainvert,
  output logic             bnegate,
  output logic [1:0]       operation,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [REGW-1:0]  ex_write_reg,
  output logic [REGW-1:0]  ex_rs,
  output logic [REGW-1:0]  ex_rt,
  output logic [4:0]       ex_ctrl,
  output logic             ex_valid,
  output logic             illegal_funct
);

  logic             valid_q, valid_d;
  logic [4:0]       ctrl_q, ctrl_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [5:0]       funct_q, funct_d;
  logic [WIDTH-1:0] rs_data_q, rs_data_d;
  logic [WIDTH-1:0] rt_data_q, rt_data_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [REGW-1:0]  rs_q, rs_d;
  logic [REGW-1:0]  rt_q, rt_d;
  logic [REGW-1:0]  rd_q, rd_d;
  logic             alu_src_q, alu_src_d;
  logic             reg_dst_q, reg_dst_d;

  // Next state: flush inserts a bubble (overriding stall), stall holds, otherwise load from ID.
  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    alu_op_d  = alu_op_q;
    funct_d   = funct_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    alu_src_d = alu_src_q;
    reg_dst_d = reg_dst_q;
    if (flush) begin
      // Data registers simply hold; they are meaningless under a bubble.
      valid_d  = 1'b0;
      ctrl_d   = '0;
      alu_op_d = '0;
      rt_d     = '0;
      rd_d     = '0;
    end else if (!stall) begin
      valid_d   = id_valid;
      ctrl_d    = id_valid ? id_ctrl : 5'b0;
      alu_op_d  = id_alu_op;
      funct_d   = id_funct;
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
      alu_src_d = id_alu_src;
      reg_dst_d = id_reg_dst;
    end
  end

  // Stage registers with synchronous reset taking priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      alu_op_q  <= '0;
      funct_q   <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      alu_src_q <= 1'b0;
      reg_dst_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      alu_op_q  <= alu_op_d;
      funct_q   <= funct_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      alu_src_q <= alu_src_d;
      reg_dst_q <= reg_dst_d;
    end
  end

  logic [WIDTH-1:0] fwd_a_val, fwd_b_val;

  // Operand forwarding; select 11 is unused by the hazard unit and falls back to the register.
  always_comb begin
    unique case (fwd_a)
      2'b10:   fwd_a_val = exmem_result;
      2'b01:   fwd_a_val = memwb_result;
      default: fwd_a_val = rs_data_q;
    endcase
    unique case (fwd_b)
      2'b10:   fwd_b_val = exmem_result;
      2'b01:   fwd_b_val = memwb_result;
      default: fwd_b_val = rt_data_q;
    endcase
  end

  // Operand, store-data and destination-register selection.
  always_comb begin
    alu_a         = fwd_a_val;
    alu_b         = alu_src_q ? imm_q : fwd_b_val;
    ex_store_data = fwd_b_val;
    ex_write_reg  = reg_dst_q ? rd_q : rt_q;
    ex_rs         = rs_q;
    ex_rt         = rt_q;
    ex_ctrl       = ctrl_q;
    ex_valid      = valid_q;
  end

  // ALU control decode into {ainvert, bnegate, operation}; unknown R-type functs default to add.
  always_comb begin
    ainvert       = 1'b0;
    bnegate       = 1'b0;
    operation     = 2'b10;
    illegal_funct = 1'b0;
    case (alu_op_q)
      3'b001: bnegate = 1'b1;
      3'b011: operation = 2'b00;
      3'b100: operation = 2'b01;
      3'b101: begin
        bnegate   = 1'b1;
        operation = 2'b11;
      end
      3'b010: begin
        case (funct_q)
          6'b100000: operation = 2'b10;
          6'b100010: bnegate = 1'b1;
          6'b100100: operation = 2'b00;
          6'b100101: operation = 2'b01;
          6'b101010: begin
            bnegate   = 1'b1;
            operation = 2'b11;
          end
          6'b100111: begin
            ainvert   = 1'b1;
            bnegate   = 1'b1;
            operation = 2'b00;
          end
          default: illegal_funct = valid_q;
        endcase
      end
      default: operation = 2'b10;
    endcase
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios followed by random traffic,
// all compared against an instruction-level model of the stage contents.
module tb_id_ex_operand_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned REGW  = 5;

  logic             clk = 1'b0;
  logic             reset, stall, flush, id_valid;
  logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
  logic [REGW-1:0]  id_rs, id_rt, id_rd;
  logic [5:0]       id_funct;
  logic [2:0]       id_alu_op;
  logic             id_alu_src, id_reg_dst;
  logic [4:0]       id_ctrl;
  logic [1:0]       fwd_a, fwd_b;
  logic [WIDTH-1:0] exmem_result, memwb_result;
  logic [WIDTH-1:0] alu_a, alu_b, ex_store_data;
  logic             ainvert, bnegate, ex_valid, illegal_funct;
  logic [1:0]       operation;
  logic [REGW-1:0]  ex_write_reg, ex_rs, ex_rt;
  logic [4:0]       ex_ctrl;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_ctrl(id_ctrl), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .ainvert(ainvert), .bnegate(bnegate),
    .operation(operation), .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
    .illegal_funct(illegal_funct)
  );

  // Instruction sitting in EX as the model sees it; bubble marks operand data as don't-care.
  typedef struct {
    logic             valid;
    logic [4:0]       ctrl;
    logic [2:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_data, rt_data, imm;
    logic [REGW-1:0]  rs, rt, rd;
    logic             alu_src, reg_dst;
    logic             bubble;
  } ex_instr_t;

  ex_instr_t m;
  int n_vec = 0;
  int n_err = 0;

  logic [5:0] legal_functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU control as {illegal, ainvert, bnegate, operation} by instruction meaning.
  function automatic logic [4:0] ref_ctl(input logic [2:0] op, input logic [5:0] f,
                                         input logic v);
    logic [4:0] c_add, c_sub, c_and, c_or, c_slt, c_nor;
    c_add = 5'b00010; c_sub = 5'b00110; c_and = 5'b00000;
    c_or  = 5'b00001; c_slt = 5'b00111; c_nor = 5'b01100;
    case (op)
      3'b001: return c_sub;
      3'b011: return c_and;
      3'b100: return c_or;
      3'b101: return c_slt;
      3'b010: begin
        if (f == 6'h20) return c_add;
        if (f == 6'h22) return c_sub;
        if (f == 6'h24) return c_and;
        if (f == 6'h25) return c_or;
        if (f == 6'h2a) return c_slt;
        if (f == 6'h27) return c_nor;
        return {v, 4'b0010};
      end
      default: return c_add;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [1:0] sel, input logic [WIDTH-1:0] reg_v);
    if (sel == 2'b10) return exmem_result;
    if (sel == 2'b01) return memwb_result;
    return reg_v;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m = '{valid: 1'b0, ctrl: '0, alu_op: '0, funct: '0, rs_data: '0, rt_data: '0, imm: '0,
            rs: '0, rt: '0, rd: '0, alu_src: 1'b0, reg_dst: 1'b0, bubble: 1'b0};
    end else if (flush) begin
      m.valid = 1'b0; m.ctrl = '0; m.alu_op = '0; m.rt = '0; m.rd = '0; m.bubble = 1'b1;
    end else if (!stall) begin
      m = '{valid: id_valid, ctrl: id_valid ? id_ctrl : 5'b0, alu_op: id_alu_op,
            funct: id_funct, rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm,
            rs: id_rs, rt: id_rt, rd: id_rd, alu_src: id_alu_src, reg_dst: id_reg_dst,
            bubble: 1'b0};
    end
  endtask

  task automatic compare_all();
    logic [4:0] c;
    c = ref_ctl(m.alu_op, m.funct, m.valid);
    check("ex_valid", 32'(ex_valid), 32'(m.valid));
    check("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
    check("alu_ctl", {27'b0, illegal_funct, ainvert, bnegate, operation}, 32'(c));
    check("ex_write_reg", 32'(ex_write_reg), 32'(m.reg_dst ? m.rd : m.rt));
    check("ex_rt", 32'(ex_rt), 32'(m.rt));
    if (!m.bubble || fwd_a inside {2'b01, 2'b10})
      check("alu_a", alu_a, pick(fwd_a, m.rs_data));
    if (!m.bubble || fwd_b inside {2'b01, 2'b10})
      check("ex_store_data", ex_store_data, pick(fwd_b, m.rt_data));
    if (!m.bubble) begin
      check("alu_b", alu_b, m.alu_src ? m.imm : pick(fwd_b, m.rt_data));
      check("ex_rs", 32'(ex_rs), 32'(m.rs));
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rand_id();
    id_valid   = 1'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
    id_funct   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_functs[$urandom_range(0, 5)];
    id_alu_op  = 3'($urandom);
    id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
    id_ctrl    = 5'($urandom);
  endtask

  task automatic rand_fwd();
    fwd_a = 2'($urandom); fwd_b = 2'($urandom);
    exmem_result = $urandom; memwb_result = $urandom;
  endtask

  task automatic load_rtype(input logic [5:0] f);
    id_valid = 1'b1; id_alu_op = 3'b010; id_funct = f; id_alu_src = 1'b0; id_reg_dst = 1'b1;
    id_ctrl = 5'b10000;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_id();
    rand_fwd();
    fwd_a = 2'b00; fwd_b = 2'b00;

    // Reset with arbitrary ID inputs.
    for (int i = 0; i < 2; i++) begin
      rand_id();
      cycle();
    end
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'(ex_ctrl), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_op", {28'b0, ainvert, bnegate, operation}, 32'b0010);
    reset = 1'b0;

    // R-type sub.
    load_rtype(6'b100010);
    id_rs_data = 32'hA; id_rt_data = 32'h3; id_rd = 5'd7;
    cycle();
    check("sub_a", alu_a, 32'hA);
    check("sub_b", alu_b, 32'h3);
    check("sub_ctl", {28'b0, ainvert, bnegate, operation}, 32'b0110);
    check("sub_wr", 32'(ex_write_reg), 32'd7);
    check("sub_valid", 32'(ex_valid), 32'd1);

    // Forwarding priority sweep within one cycle.
    id_rs_data = 32'h11; id_alu_src = 1'b0;
    cycle();
    exmem_result = 32'h22; memwb_result = 32'h33;
    begin
      logic [1:0]       sels [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
      logic [WIDTH-1:0] exps [4] = '{32'h11, 32'h22, 32'h33, 32'h11};
      for (int i = 0; i < 4; i++) begin
        fwd_a = sels[i];
        #1;
        check("fwd_sweep", alu_a, exps[i]);
        compare_all();
      end
    end
    id_alu_src = 1'b1; id_imm = 32'hFFFF_FFFC;
    cycle();
    fwd_b = 2'b10;
    #1;
    check("imm_b", alu_b, 32'hFFFF_FFFC);
    check("fwd_store", ex_store_data, 32'h22);
    compare_all();

    // lw held through a 3-cycle stall, then flushed while still stalled.
    fwd_a = 2'b00; fwd_b = 2'b00;
    id_valid = 1'b1; id_alu_op = 3'b000; id_ctrl = 5'b11100; id_alu_src = 1'b1;
    id_reg_dst = 1'b0; id_rt = 5'd9;
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      cycle();
      check("stall_ctrl", 32'(ex_ctrl), 32'b11100);
    end
    flush = 1'b1;
    cycle();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_ctrl", 32'(ex_ctrl), 32'd0);
    check("flush_op", 32'(operation), 32'b10);
    stall = 1'b0; flush = 1'b0;

    // Decode sweep over every legal funct, then an illegal one in and out of a bubble.
    for (int i = 0; i < 6; i++) begin
      load_rtype(legal_functs[i]);
      cycle();
    end
    check("nor_ctl", {28'b0, ainvert, bnegate, operation}, 32'b1100);
    load_rtype(6'b001000);
    cycle();
    check("illegal_on", 32'(illegal_funct), 32'd1);
    flush = 1'b1;
    cycle();
    check("illegal_flushed", 32'(illegal_funct), 32'd0);
    flush = 1'b0;

    // Reset wins over stall.
    id_valid = 1'b1; id_alu_op = 3'b000; id_ctrl = 5'b00010;
    cycle();
    stall = 1'b1;
    cycle();
    reset = 1'b1;
    cycle();
    check("rst_stall_valid", 32'(ex_valid), 32'd0);
    check("rst_stall_ctrl", 32'(ex_ctrl), 32'd0);
    reset = 1'b0; stall = 1'b0;

    // Random traffic with occasional reset, flush and stall.
    for (int i = 0; i < 2000; i++) begin
      rand_id();
      reset = ($urandom_range(0, 31) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      model_edge();
      @(posedge clk);
      #1;
      rand_fwd();
      #1;
      compare_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
